// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 receive front end.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN              = 11;
    localparam int DATA_BITS              = FRAME_LEN - 3;
    localparam int FILTER_LEN_DEFAULT     = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 20000;

    // True when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : Two-flop synchroniser plus run-length debounce for one PS/2 line;
//            emits the filtered level and a one-cycle falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_run_cnt;

    // The level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            level     <= 1'b1;
            fall      <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            r_sync1 <= line_in;
            r_sync2 <= r_sync1;
            fall    <= 1'b0;
            if (r_sync2 == level) begin
                r_run_cnt <= '0;
            end else if (r_run_cnt == C_LAST) begin
                level     <= r_sync2;
                fall      <= level;
                r_run_cnt <= '0;
            end else begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_controller
// Purpose  : PS/2 device-to-host deframer with a FWFT byte FIFO on a slow-IO
//            read port. Define PS2_PARITY_CHECK_EN to drop bad frames.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int FILTER_LEN     = FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       io_rd_valid,
    output logic [7:0] io_rd_data,
    input  logic       io_rd_ack,
    output logic       io_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]      C_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         C_BIT_LAST     = 3'(DATA_BITS - 1);
    localparam logic [FIFO_AW:0]   C_FULL_CNT     = (FIFO_AW + 1)'(DEPTH);

    logic w_clk_fall;
    logic w_data_level;
    logic w_unused_clk_level;
    logic w_unused_data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_clock),
        .level   (w_unused_clk_level),
        .fall    (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_data),
        .level   (w_data_level),
        .fall    (w_unused_data_fall)
    );

    // ------------------------------------------------------------------
    // Frame deframer
    // ------------------------------------------------------------------
    ps2_state_e    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_idle_cnt;
    logic          r_push;
    logic [7:0]    r_push_data;
    logic          w_frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    assign w_frame_ok = odd_parity_ok(r_shift, r_parity) && w_data_level;
`else
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_idle_cnt  <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_push <= 1'b0;
            if (r_state == ST_IDLE || w_clk_fall) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            // A stalled device abandons the partial frame without pushing.
            if (r_state != ST_IDLE && !w_clk_fall && r_idle_cnt == C_TIMEOUT_LAST) begin
                r_state <= ST_IDLE;
            end else if (w_clk_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data_level) begin
                            r_state   <= ST_SHIFT;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        r_shift   <= {w_data_level, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == C_BIT_LAST) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_data_level;
`endif
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state     <= ST_IDLE;
                        r_push      <= w_frame_ok;
                        r_push_data <= r_shift;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word fall-through receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_pop;
    logic               w_full;
    logic               w_write;

    assign w_pop   = io_rd_ack && (r_count != '0);
    assign w_full  = (r_count == C_FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_write = r_push && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            io_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_push && !w_write) begin
                io_overflow <= 1'b1;
            end
        end
    end

    assign io_rd_valid = (r_count != '0);
    assign io_rd_data  = io_rd_valid ? r_mem[r_rd_ptr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_controller
// Purpose  : Directed self-checking bench for ps2_rx_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_controller;

    localparam int HALF    = 20;
    localparam int FILT    = 8;
    localparam int TIMEOUT = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       io_rd_valid;
    logic [7:0] io_rd_data;
    logic       io_rd_ack = 1'b0;
    logic       io_overflow;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    ps2_rx_controller #(
        .FIFO_AW        (3),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .ps2_clock   (ps2_clock),
        .ps2_data    (ps2_data),
        .io_rd_valid (io_rd_valid),
        .io_rd_data  (io_rd_data),
        .io_rd_ack   (io_rd_ack),
        .io_overflow (io_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clock = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clock = 1'b1;
    endtask

    // Sends start + nbits data bits; a full frame (nbits==8) adds parity and
    // stop, and reports cycles from the stop falling edge to io_rd_valid.
    task automatic send_frame(input logic [7:0] b, input logic par, input int nbits,
                              output int lat_o);
        lat_o = -1;
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        if (nbits == 8) begin
            ps2_bit(par);
            ps2_data = 1'b1;
            repeat (HALF) @(negedge clk);
            ps2_clock = 1'b0;
            for (int i = 1; i <= HALF; i++) begin
                @(posedge clk);
                #1;
                if (lat_o < 0 && io_rd_valid) lat_o = i;
            end
            @(negedge clk);
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        io_rd_ack = 1'b1;
        @(negedge clk);
        io_rd_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset_valid", io_rd_valid, 0);
        chk("reset_data", io_rd_data, 8'h00);
        chk("reset_ovf", io_overflow, 0);

        // Single 0x85 frame, latency bound, then pop
        send_frame(8'h85, 1'b0, 8, lat);
        chk("lat_in_bound", (lat >= 1 && lat <= FILT + 4), 1);
        chk("single_valid", io_rd_valid, 1);
        chk("single_data", io_rd_data, 8'h85);
        pop();
        chk("single_popped", io_rd_valid, 0);
        pop();
        chk("ack_empty_ignored", io_rd_valid, 0);

        // Stream of 20 frames drained by the reader
        for (int f = 0; f < 20; f++) begin
            send_frame(8'h85, 1'b0, 8, lat);
            chk("stream_data", io_rd_data, 8'h85);
            pop();
            chk("stream_empty", io_rd_valid, 0);
        end
        chk("stream_ovf", io_overflow, 0);

        // Fill and overflow: 9 frames 0x01..0x09 with no acks
        for (int f = 1; f <= 9; f++) begin
            logic [7:0] v;
            v = 8'(f);
            send_frame(v, ~^v, 8, lat);
            if (f == 8) chk("full_no_ovf", io_overflow, 0);
        end
        chk("ovf_set", io_overflow, 1);
        for (int f = 1; f <= 8; f++) begin
            chk("ovf_valid", io_rd_valid, 1);
            chk("ovf_order", io_rd_data, 32'(f));
            pop();
        end
        chk("ovf_drained", io_rd_valid, 0);
        chk("ovf_sticky", io_overflow, 1);
        pulse_reset();
        chk("ovf_cleared", io_overflow, 0);

        // Bad parity on 0x85
        send_frame(8'h85, 1'b1, 8, lat);
`ifdef PS2_PARITY_CHECK_EN
        chk("badpar_dropped", io_rd_valid, 0);
`else
        chk("badpar_valid", io_rd_valid, 1);
        chk("badpar_data", io_rd_data, 8'h85);
        pop();
`endif

        // Abort after 4 data bits, idle past the timeout, then 0x1C
        send_frame(8'h33, 1'b0, 4, lat);
        repeat (TIMEOUT + 200) @(negedge clk);
        chk("abort_nothing", io_rd_valid, 0);
        send_frame(8'h1C, 1'b0, 8, lat);
        chk("abort_valid", io_rd_valid, 1);
        chk("abort_data", io_rd_data, 8'h1C);
        pop();
        chk("abort_single", io_rd_valid, 0);

        // Short low glitch on ps2_clock while data is low
        ps2_data = 1'b0;
        repeat (15) @(negedge clk);
        ps2_clock = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clock = 1'b1;
        repeat (15) @(negedge clk);
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_nothing", io_rd_valid, 0);
        send_frame(8'h5A, 1'b1, 8, lat);
        chk("glitch_next_data", io_rd_data, 8'h5A);
        pop();
        chk("glitch_next_single", io_rd_valid, 0);

        // Reset mid-frame then a fresh frame
        send_frame(8'hF0, 1'b0, 5, lat);
        pulse_reset();
        send_frame(8'h1C, 1'b0, 8, lat);
        chk("rstmid_data", io_rd_data, 8'h1C);
        pop();
        chk("rstmid_single", io_rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
